// File: rtl/stream_sink_checker.sv
// stream_sink_checker
//   Consumer end of a valid/ready byte stream. Drives a registered ready under
//   a selectable backpressure policy, checks that accepted data increments by
//   one per beat, watches the upstream side for valid/ready protocol
//   violations, and exposes saturating beat/error/stall counters.
//
// Ports
//   clk            clock, all state on rising edge
//   reset          asynchronous, active-high reset
//   enable_i       start/continue consuming; low returns to IDLE
//   clear_i        synchronous clear of counters, expected value, sticky flag
//   mode_i         backpressure: 00 always, 01 LFSR, 10 never, 11 one in four
//   stop_on_err_i  halt on first data mismatch
//   valid_i        upstream valid
//   data_i         upstream data
//   ready_o        registered ready
//   beat_cnt_o     accepted beats (saturating)
//   err_cnt_o      data mismatches (saturating)
//   stall_cnt_o    cycles with valid_i=1 and ready_o=0 (saturating)
//   expect_o       next expected data value
//   proto_err_o    sticky protocol-violation flag
//   halted_o       high while in HALT
module stream_sink_checker #(
  parameter int                DATA_W    = 8,
  parameter int                CNT_W     = 16,
  parameter logic [DATA_W-1:0] START_VAL = DATA_W'(1),
  parameter logic [7:0]        LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic [1:0]        mode_i,
  input  logic              stop_on_err_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic [CNT_W-1:0]  beat_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [DATA_W-1:0] expect_o,
  output logic              proto_err_o,
  output logic              halted_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // An all-zero seed would lock the LFSR up.
  localparam logic [7:0]       SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam int               N_CNT    = 3;

  state_t            state_reg, state_next;
  logic              ready_reg, ready_next;
  logic [7:0]        lfsr_reg, lfsr_next;
  logic [1:0]        phase_reg, phase_next;
  logic [DATA_W-1:0] expect_reg;
  logic              proto_err_reg;
  // Remembers an offer that was stalled last cycle so we can verify it is held.
  logic              hold_reg;
  logic [DATA_W-1:0] hold_data_reg;

  logic handshake;
  logic mismatch;
  logic stall;

  assign handshake = valid_i & ready_reg;
  assign mismatch  = handshake & (data_i != expect_reg);
  assign stall     = valid_i & ~ready_reg;

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (enable_i) state_next = ST_RUN;
        ST_RUN: begin
          if (mismatch && stop_on_err_i) state_next = ST_HALT;
          else if (!enable_i)            state_next = ST_IDLE;
        end
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Ready is only offered when we are in RUN now and stay there, so a halt,
  // disable or clear drops ready at the very edge that causes it.
  always_comb begin
    ready_next = 1'b0;
    if (state_reg == ST_RUN && state_next == ST_RUN) begin
      case (mode_i)
        2'b00: ready_next = 1'b1;
        2'b01: ready_next = lfsr_reg[0];
        2'b10: ready_next = 1'b0;
        2'b11: ready_next = (phase_reg == 2'd3);
        default: ready_next = 1'b0;
      endcase
    end
  end

  assign halted_o = (state_reg == ST_HALT);
  assign ready_o  = ready_reg;

  // ------------------------------------------------ backpressure sources ----
  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; both sources only advance in RUN and
  // survive a clear so the ready pattern keeps running.
  always_comb begin
    lfsr_next  = lfsr_reg;
    phase_next = phase_reg;
    if (state_reg == ST_RUN) begin
      lfsr_next  = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
      phase_next = phase_reg + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_reg  <= SEED_EFF;
      phase_reg <= 2'd0;
    end else begin
      lfsr_reg  <= lfsr_next;
      phase_reg <= phase_next;
    end
  end

  // ------------------------------------------ data and protocol checking ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expect_reg    <= START_VAL;
      proto_err_reg <= 1'b0;
      hold_reg      <= 1'b0;
      hold_data_reg <= '0;
    end else if (clear_i) begin
      // Dropping the history avoids flagging an upstream that legitimately
      // withdraws its offer across a clear.
      expect_reg    <= START_VAL;
      proto_err_reg <= 1'b0;
      hold_reg      <= 1'b0;
      hold_data_reg <= '0;
    end else begin
      if (hold_reg && (!valid_i || data_i != hold_data_reg)) proto_err_reg <= 1'b1;
      hold_reg      <= stall;
      hold_data_reg <= data_i;
      if (handshake) begin
        // On a mismatch resync to the received value so a single dropped
        // beat costs exactly one error.
        expect_reg <= mismatch ? data_i + 1'b1 : expect_reg + 1'b1;
      end
    end
  end

  assign expect_o    = expect_reg;
  assign proto_err_o = proto_err_reg;

  // ---------------------------------------------- saturating counters ----
  logic [N_CNT-1:0]            cnt_inc;
  logic [N_CNT-1:0][CNT_W-1:0] cnt_q;

  assign cnt_inc[0] = handshake;
  assign cnt_inc[1] = mismatch;
  assign cnt_inc[2] = stall;

  generate
    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      cnt_reg <= '0;
        else if (clear_i)                               cnt_reg <= '0;
        else if (cnt_inc[gi] && (cnt_reg != CNT_MAX))   cnt_reg <= cnt_reg + 1'b1;
      end
      assign cnt_q[gi] = cnt_reg;
    end
  endgenerate

  assign beat_cnt_o  = cnt_q[0];
  assign err_cnt_o   = cnt_q[1];
  assign stall_cnt_o = cnt_q[2];

endmodule

// File: tb/tb_stream_sink_checker.sv
module tb_stream_sink_checker;

  localparam logic [7:0] SEED  = 8'hA5;
  localparam logic [7:0] START = 8'h01;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_i;
  logic        clear_i;
  logic [1:0]  mode_i;
  logic        stop_on_err_i;
  logic        valid_i;
  logic [7:0]  data_i;

  logic        ready_o;
  logic [15:0] beat_cnt_o, err_cnt_o, stall_cnt_o;
  logic [7:0]  expect_o;
  logic        proto_err_o, halted_o;

  // Second instance: start value near the wrap point, narrow counters.
  logic        w_ready;
  logic [3:0]  w_beat, w_err, w_stall;
  logic [7:0]  w_expect;
  logic        w_proto, w_halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_sink_checker #(.DATA_W(8), .CNT_W(16), .START_VAL(START), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .clear_i(clear_i), .mode_i(mode_i),
    .stop_on_err_i(stop_on_err_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .beat_cnt_o(beat_cnt_o), .err_cnt_o(err_cnt_o),
    .stall_cnt_o(stall_cnt_o), .expect_o(expect_o), .proto_err_o(proto_err_o),
    .halted_o(halted_o)
  );

  stream_sink_checker #(.DATA_W(8), .CNT_W(4), .START_VAL(8'hFE), .LFSR_SEED(SEED)) dut_w (
    .clk(clk), .reset(reset), .enable_i(enable_i), .clear_i(clear_i), .mode_i(mode_i),
    .stop_on_err_i(stop_on_err_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(w_ready), .beat_cnt_o(w_beat), .err_cnt_o(w_err),
    .stall_cnt_o(w_stall), .expect_o(w_expect), .proto_err_o(w_proto),
    .halted_o(w_halted)
  );

  // ---------------- behavioural reference model ----------------
  int         m_beat, m_err, m_stall, m_phase;
  logic [7:0] m_exp, m_lfsr, h_data;
  bit         m_ready, m_run, m_halt, m_proto, h_valid;
  logic [7:0] tx_q[$];

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_beat = 0; m_err = 0; m_stall = 0; m_phase = 0;
    m_exp = START; m_lfsr = SEED; h_data = 8'h00;
    m_ready = 0; m_run = 0; m_halt = 0; m_proto = 0; h_valid = 0;
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".ready"},  32'(ready_o),     32'(m_ready));
    check({ph, ".beat"},   32'(beat_cnt_o),  32'(m_beat));
    check({ph, ".err"},    32'(err_cnt_o),   32'(m_err));
    check({ph, ".stall"},  32'(stall_cnt_o), 32'(m_stall));
    check({ph, ".expect"}, 32'(expect_o),    32'(m_exp));
    check({ph, ".proto"},  32'(proto_err_o), 32'(m_proto));
    check({ph, ".halted"}, 32'(halted_o),    32'(m_halt));
  endtask

  // Advance one clock: apply the consumer rules to the inputs present at the
  // edge, then compare every DUT output with the model just after the edge.
  task automatic tick(input string ph);
    bit         hs, bad, was_run, run_n, halt_n, rdy_n;
    logic [7:0] lfsr_n;
    hs      = valid_i && m_ready;
    bad     = hs && (data_i != m_exp);
    was_run = m_run;
    lfsr_n  = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    if (clear_i) begin
      m_beat = 0; m_err = 0; m_stall = 0; m_exp = START; m_proto = 0;
      h_valid = 0; m_run = 0; m_halt = 0; m_ready = 0;
    end else begin
      if (valid_i && !m_ready) m_stall = sat16(m_stall + 1);
      if (h_valid && (!valid_i || data_i != h_data)) m_proto = 1;
      h_valid = valid_i && !m_ready;
      h_data  = data_i;
      if (hs) begin
        m_beat = sat16(m_beat + 1);
        if (bad) begin
          m_err = sat16(m_err + 1);
          m_exp = data_i + 8'd1;
        end else begin
          m_exp = m_exp + 8'd1;
        end
      end
      run_n = m_run; halt_n = m_halt;
      if (!m_halt) begin
        if (!m_run)                  run_n = enable_i;
        else if (bad && stop_on_err_i) begin run_n = 0; halt_n = 1; end
        else if (!enable_i)          run_n = 0;
      end
      rdy_n = 0;
      if (m_run && run_n) begin
        case (mode_i)
          2'd0: rdy_n = 1;
          2'd1: rdy_n = m_lfsr[0];
          2'd2: rdy_n = 0;
          default: rdy_n = (m_phase == 3);
        endcase
      end
      m_ready = rdy_n; m_run = run_n; m_halt = halt_n;
    end
    if (was_run) begin
      m_lfsr  = lfsr_n;
      m_phase = (m_phase + 1) % 4;
    end
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  task automatic idle(input int n, input string ph);
    for (int i = 0; i < n; i++) tick(ph);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    compare_all("reset");
    valid_i = 1'b0;
    clear_i = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Sender: offers tx_q in order, holds an offer until accepted.
  task automatic run_stream(input int budget, input bit rand_valid, input bit must_drain, input string ph);
    bit hold = 0;
    bit acc;
    int cyc = 0;
    while (tx_q.size() > 0 && cyc < budget) begin
      if (!hold) valid_i = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      data_i = tx_q[0];
      acc = valid_i && m_ready;
      tick(ph);
      if (acc) void'(tx_q.pop_front());
      hold = valid_i && !acc;
      cyc++;
    end
    if (must_drain) check({ph, ".drain_left"}, 32'(tx_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable_i = 0; clear_i = 0; mode_i = 2'd0;
    stop_on_err_i = 0; valid_i = 0; data_i = 8'h00;
    do_reset();
    check("rst.ready", 32'(ready_o), 32'd0);
    check("rst.beat", 32'(beat_cnt_o), 32'd0);
    check("rst.expect", 32'(expect_o), 32'd1);
    check("rst.halted", 32'(halted_o), 32'd0);
    check("rst.w_expect", 32'(w_expect), 32'hFE);

    // Mode 00, back-to-back 1..200 once ready is up.
    enable_i = 1; mode_i = 2'd0;
    idle(2, "m00.start");
    for (int v = 1; v <= 200; v++) tx_q.push_back(8'(v));
    run_stream(400, 0, 1, "m00");
    valid_i = 0; enable_i = 0;
    idle(2, "m00.end");
    check("m00.beat", 32'(beat_cnt_o), 32'd200);
    check("m00.err", 32'(err_cnt_o), 32'd0);
    check("m00.expect", 32'(expect_o), 32'd201);
    check("m00.stall", 32'(stall_cnt_o), 32'd0);
    check("m00.proto", 32'(proto_err_o), 32'd0);
    check("m00.w_beat_sat", 32'(w_beat), 32'd15);
    check("m00.w_err", 32'(w_err), 32'd1);

    // Mode 01, random valid, LFSR from seed.
    do_reset();
    enable_i = 1; mode_i = 2'd1;
    for (int v = 1; v <= 200; v++) tx_q.push_back(8'(v));
    run_stream(4000, 1, 1, "m01");
    valid_i = 0; enable_i = 0;
    idle(2, "m01.end");
    check("m01.beat", 32'(beat_cnt_o), 32'd200);
    check("m01.err", 32'(err_cnt_o), 32'd0);
    check("m01.proto", 32'(proto_err_o), 32'd0);

    // Skipped value, no stop.
    do_reset();
    enable_i = 1; mode_i = 2'd0; stop_on_err_i = 0;
    idle(2, "skip.start");
    tx_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7};
    run_stream(20, 0, 1, "skip");
    valid_i = 0;
    idle(1, "skip.end");
    check("skip.err", 32'(err_cnt_o), 32'd1);
    check("skip.expect", 32'(expect_o), 32'd8);
    check("skip.beat", 32'(beat_cnt_o), 32'd6);

    // Skipped value with stop-on-error.
    do_reset();
    stop_on_err_i = 1;
    idle(2, "stop.start");
    tx_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7};
    run_stream(15, 0, 0, "stop");
    check("stop.halted", 32'(halted_o), 32'd1);
    check("stop.beat", 32'(beat_cnt_o), 32'd5);
    check("stop.err", 32'(err_cnt_o), 32'd1);
    check("stop.ready", 32'(ready_o), 32'd0);
    tx_q.delete();
    valid_i = 0; clear_i = 1;
    tick("stop.clear");
    clear_i = 0; stop_on_err_i = 0;
    check("stop.cleared", 32'(halted_o), 32'd0);

    // Mode 10: held offer stalls, then dropped valid.
    mode_i = 2'd2; valid_i = 1; data_i = 8'h33;
    idle(5, "m10.hold");
    check("m10.stall", 32'(stall_cnt_o), 32'd5);
    check("m10.w_stall", 32'(w_stall), 32'd5);
    check("m10.proto_before", 32'(proto_err_o), 32'd0);
    valid_i = 0;
    tick("m10.drop");
    check("m10.proto_drop", 32'(proto_err_o), 32'd1);
    clear_i = 1;
    tick("m10.clear");
    clear_i = 0; valid_i = 1; data_i = 8'h44;
    idle(3, "m10.hold2");
    check("m10.proto_held", 32'(proto_err_o), 32'd0);
    data_i = 8'h45;
    tick("m10.change");
    check("m10.proto_change", 32'(proto_err_o), 32'd1);
    valid_i = 0; clear_i = 1;
    tick("m10.clear2");
    clear_i = 0;

    // Wrap across FF -> 00 on the FE-start instance.
    mode_i = 2'd0;
    idle(2, "wrap.start");
    tx_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_stream(20, 0, 1, "wrap");
    valid_i = 0;
    idle(1, "wrap.end");
    check("wrap.w_err", 32'(w_err), 32'd0);
    check("wrap.w_expect", 32'(w_expect), 32'h02);
    check("wrap.err", 32'(err_cnt_o), 32'd1);
    check("wrap.expect", 32'(expect_o), 32'h02);

    // Reset while a beat is in flight.
    for (int v = 1; v <= 50; v++) tx_q.push_back(8'(v));
    run_stream(10, 0, 0, "rmid");
    valid_i = 1; data_i = tx_q[0];
    tx_q.delete();
    do_reset();
    check("rmid.beat", 32'(beat_cnt_o), 32'd0);
    check("rmid.expect", 32'(expect_o), 32'd1);
    idle(3, "rmid.after");
    check("rmid.proto", 32'(proto_err_o), 32'd0);

    // Clear on a handshake cycle.
    idle(1, "clr.start");
    for (int v = 1; v <= 10; v++) tx_q.push_back(8'(v));
    run_stream(4, 0, 0, "clr");
    check("clr.ready_before", 32'(ready_o), 32'd1);
    valid_i = 1; data_i = tx_q[0]; clear_i = 1;
    tick("clr.edge");
    clear_i = 0; valid_i = 0;
    tx_q.delete();
    check("clr.beat", 32'(beat_cnt_o), 32'd0);
    check("clr.expect", 32'(expect_o), 32'd1);
    check("clr.ready", 32'(ready_o), 32'd0);
    idle(2, "clr.after");
    check("clr.proto", 32'(proto_err_o), 32'd0);
    enable_i = 0;
    idle(1, "done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
